// File: rtl/io_pkg.sv
// Shared seven-segment encodings, display modes and sizing helpers for the I/O display block.
package io_pkg;

    typedef enum logic [1:0] {MODE_DASH, MODE_OUT, MODE_IN, MODE_HALT} mode_e;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_L     = 7'b1000111;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Decimal digits needed for a w-bit unsigned value: ceil(w * log10(2))
    function automatic int ceil_log10_2(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, rising-edge pulse.
module io_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYC);

    logic          sync1, sync2, level;
    logic [CW-1:0] cnt;

    // The debounced level starts high, so a key held through reset must be
    // released and pressed again before it can produce a pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                cnt   <= '0;
                level <= sync2;
                pulse <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_display_ctrl.sv
// Seven-segment I/O display: sequential double-dabble conversion with signed display,
// leading-zero blanking and overflow, plus debounced switch capture on Enter.
module io_display_ctrl
    import io_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DATA_W       = 32,
    parameter int SW_W         = 10,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_req,
    input  logic                    out_req,
    input  logic                    halt,
    input  logic                    enter,
    input  logic                    signed_mode,
    input  logic [SW_W-1:0]         sw,
    input  logic [DATA_W-1:0]       output_num,
    output logic [DATA_W-1:0]       input_data,
    output logic                    input_valid,
    output logic                    busy,
    output logic [7*NUM_DIGITS-1:0] hex
);
    localparam int BCD_DIG = ceil_log10_2(DATA_W);
    localparam int BW      = 4 * BCD_DIG;
    localparam int NB      = (BCD_DIG > NUM_DIGITS) ? BCD_DIG : NUM_DIGITS;
    localparam int HD      = (NUM_DIGITS < 3) ? 3 : NUM_DIGITS;
    localparam int CNT_W   = $clog2(DATA_W);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_FORMAT} state_e;

    state_e              state;
    mode_e               mode, last_mode;
    logic [DATA_W-1:0]   value, last_value, mag;
    logic                last_sgn, neg, enter_pulse, req_diff, conv_mode;
    logic [BW-1:0]       bcd, bcd_adj;
    logic [4*NB-1:0]     bcd_ext;
    logic [CNT_W-1:0]    cnt;
    logic [7*HD-1:0]     fmt_hex, halt_hex;
    int                  msd;
    logic                ovf;

    io_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_enter (
        .clk(clk), .reset(reset), .raw(enter), .pulse(enter_pulse)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            input_data  <= '0;
            input_valid <= 1'b0;
        end else begin
            input_valid <= 1'b0;
            if (enter_pulse && in_req && !out_req && !halt) begin
                input_data  <= DATA_W'(sw);
                input_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        mode  = MODE_DASH;
        value = '0;
        if (halt) begin
            mode = MODE_HALT;
        end else if (out_req && !in_req) begin
            mode  = MODE_OUT;
            value = output_num;
        end else if (in_req && !out_req) begin
            mode  = MODE_IN;
            value = DATA_W'(sw);
        end
    end

    assign conv_mode = (mode == MODE_OUT) || (mode == MODE_IN);
    assign req_diff  = (mode != last_mode) || (value != last_value) || (signed_mode != last_sgn);

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BCD_DIG; i++)
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    always_comb begin
        bcd_ext = '0;
        bcd_ext[BW-1:0] = bcd;
        msd = 0;
        for (int i = 0; i < NB; i++)
            if (bcd_ext[4*i +: 4] != 4'd0) msd = i;
        ovf = 1'b0;
        for (int i = NUM_DIGITS; i < NB; i++)
            if (bcd_ext[4*i +: 4] != 4'd0) ovf = 1'b1;
        // A negative value needs one free digit left of its magnitude for the sign
        if (neg && msd >= NUM_DIGITS - 1) ovf = 1'b1;
        fmt_hex = {HD{SEG_BLANK}};
        if (ovf) begin
            fmt_hex[20:0] = {SEG_O, SEG_F, SEG_L};
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (i <= msd)                fmt_hex[7*i +: 7] = seg_digit(bcd_ext[4*i +: 4]);
                else if (neg && i == msd + 1) fmt_hex[7*i +: 7] = SEG_DASH;
            end
        end
        halt_hex = {HD{SEG_BLANK}};
        halt_hex[20:0] = {SEG_E, SEG_N, SEG_D};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            last_mode  <= MODE_DASH;
            last_value <= '0;
            last_sgn   <= 1'b0;
            neg        <= 1'b0;
            mag        <= '0;
            bcd        <= '0;
            cnt        <= '0;
            hex        <= {NUM_DIGITS{SEG_DASH}};
        end else if (!conv_mode) begin
            // Remembering the non-converting mode forces a fresh conversion on return
            state     <= S_IDLE;
            busy      <= 1'b0;
            last_mode <= mode;
            hex       <= (mode == MODE_HALT) ? halt_hex[7*NUM_DIGITS-1:0] : {NUM_DIGITS{SEG_DASH}};
        end else begin
            case (state)
                S_IDLE: if (req_diff) begin
                    state <= S_LOAD;
                    busy  <= 1'b1;
                end
                S_LOAD: begin
                    last_mode  <= mode;
                    last_value <= value;
                    last_sgn   <= signed_mode;
                    neg        <= signed_mode & value[DATA_W-1];
                    mag        <= (signed_mode && value[DATA_W-1]) ? -value : value;
                    bcd        <= '0;
                    cnt        <= '0;
                    state      <= S_SHIFT;
                end
                S_SHIFT: if (req_diff) begin
                    state <= S_LOAD;
                end else begin
                    bcd <= {bcd_adj[BW-2:0], mag[DATA_W-1]};
                    mag <= mag << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W - 1)) state <= S_FORMAT;
                end
                default: begin
                    hex   <= fmt_hex[7*NUM_DIGITS-1:0];
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_display_ctrl.sv
// Directed bench for io_display_ctrl: 8-digit and 4-digit instances share stimulus.
module tb_io_display_ctrl;
    logic        clk = 1'b0, reset = 1'b0;
    logic        in_req = 1'b0, out_req = 1'b0, halt = 1'b0, enter = 1'b0, signed_mode = 1'b0;
    logic [9:0]  sw = '0;
    logic [31:0] output_num = '0;
    logic [31:0] input_data, input_data4;
    logic        input_valid, input_valid4, busy, busy4;
    logic [55:0] hex;
    logic [27:0] hex4;

    int checks = 0, failures = 0, busy_cycles = 0;

    io_display_ctrl dut (
        .clk(clk), .reset(reset), .in_req(in_req), .out_req(out_req), .halt(halt),
        .enter(enter), .signed_mode(signed_mode), .sw(sw), .output_num(output_num),
        .input_data(input_data), .input_valid(input_valid), .busy(busy), .hex(hex)
    );

    io_display_ctrl #(.NUM_DIGITS(4)) dut4 (
        .clk(clk), .reset(reset), .in_req(in_req), .out_req(out_req), .halt(halt),
        .enter(enter), .signed_mode(signed_mode), .sw(sw), .output_num(output_num),
        .input_data(input_data4), .input_valid(input_valid4), .busy(busy4), .hex(hex4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] num;
        logic        sgn;
        string       e8;
        string       e4;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Expected segment pattern from a display string, leftmost character = top digit
    function automatic logic [55:0] enc(input string s);
        logic [55:0] r;
        logic [6:0]  c;
        int          n;
        r = '1;
        n = s.len();
        for (int i = 0; i < n; i++) begin
            case (s[i])
                "0": c = 7'b1000000;  "1": c = 7'b1111001;  "2": c = 7'b0100100;
                "3": c = 7'b0110000;  "4": c = 7'b0011001;  "5": c = 7'b0010010;
                "6": c = 7'b0000010;  "7": c = 7'b1111000;  "8": c = 7'b0000000;
                "9": c = 7'b0010000;  "-": c = 7'b0111111;  "E": c = 7'b0000110;
                "n": c = 7'b0101011;  "d": c = 7'b0100001;  "O": c = 7'b1000000;
                "F": c = 7'b0001110;  "L": c = 7'b1000111;
                default: c = 7'b1111111;
            endcase
            r[7*(n-1-i) +: 7] = c;
        end
        return r;
    endfunction

    task automatic convert(input string name, input string e8, input string e4);
        int          n;
        logic [55:0] prev8;
        logic [27:0] prev4;
        logic        stable;
        logic [55:0] x4;
        prev8 = hex;
        prev4 = hex4;
        n = 0;
        while (!busy && n < 5) begin tick(); n++; end
        chk({name, " busy_rise"}, busy, 1'b1);
        n = 0;
        stable = 1'b1;
        while (busy && n < 80) begin
            if (hex != prev8 || hex4 != prev4) stable = 1'b0;
            tick();
            n++;
        end
        busy_cycles = n;
        chk({name, " busy_fall"}, busy, 1'b0);
        chk({name, " hold_old_hex"}, stable, 1'b1);
        chk({name, " hex8"}, hex, enc(e8));
        x4 = enc(e4);
        chk({name, " hex4"}, hex4, x4[27:0]);
    endtask

    initial begin
        int n, pulses;
        logic [55:0] e;
        vecs[0]  = '{32'd1234,       1'b0, "    1234", "1234"};
        vecs[1]  = '{32'hFFFFFF85,   1'b1, "    -123", "-123"};
        vecs[2]  = '{32'hFFFFFF85,   1'b0, "     OFL", " OFL"};
        vecs[3]  = '{32'h80000000,   1'b1, "     OFL", " OFL"};
        vecs[4]  = '{32'd0,          1'b0, "       0", "   0"};
        vecs[5]  = '{32'd99999999,   1'b0, "99999999", " OFL"};
        vecs[6]  = '{32'd100000000,  1'b0, "     OFL", " OFL"};
        vecs[7]  = '{32'hFF676981,   1'b1, "-9999999", " OFL"};
        vecs[8]  = '{32'hFF676980,   1'b1, "     OFL", " OFL"};
        vecs[9]  = '{32'd12345,      1'b0, "   12345", " OFL"};
        vecs[10] = '{32'd9999,       1'b0, "    9999", "9999"};
        vecs[11] = '{32'hFFFFFC19,   1'b1, "    -999", "-999"};
        vecs[12] = '{32'hFFFFFC18,   1'b1, "   -1000", " OFL"};
        vecs[13] = '{32'hFFFFFFFF,   1'b1, "      -1", "  -1"};
        vecs[14] = '{32'd7,          1'b1, "       7", "   7"};

        repeat (3) tick();
        chk("reset hex", hex, enc("--------"));
        chk("reset input_data", input_data, 32'd0);
        chk("reset input_valid", input_valid, 1'b0);
        chk("reset busy", busy, 1'b0);
        reset = 1'b1;
        repeat (25) tick();

        out_req = 1'b1;
        for (int i = 0; i < 15; i++) begin
            output_num  = vecs[i].num;
            signed_mode = vecs[i].sgn;
            convert($sformatf("vec%0d", i), vecs[i].e8, vecs[i].e4);
            if (i == 0) chk("busy_length", busy_cycles, 34);
        end

        // Both requests at once -> dashes on the next edge
        in_req = 1'b1;
        tick();
        chk("both_req dash", hex, enc("--------"));
        chk("both_req busy", busy, 1'b0);

        // IN mode: live switches shown, bouncing Enter captured once
        out_req = 1'b0;
        signed_mode = 1'b0;
        sw = 10'd1023;
        convert("in_1023", "    1023", "1023");
        for (int i = 0; i < 4; i++) begin enter = ~enter; tick(); end
        enter = 1'b1;
        n = 0;
        while (!input_valid && n < 40) begin tick(); n++; end
        chk("enter latency", n, 19);
        chk("enter data", input_data, 32'd1023);
        pulses = 0;
        for (int i = 0; i < 25; i++) begin tick(); if (input_valid) pulses++; end
        chk("enter single pulse", pulses, 0);
        enter = 1'b0;
        repeat (25) tick();

        // Capture while a conversion runs, then reset mid-shift with Enter held
        sw = 10'd5;
        enter = 1'b1;
        n = 0;
        while (!input_valid && n < 40) begin tick(); n++; end
        chk("capture during conv latency", n, 19);
        chk("capture during conv busy", busy, 1'b1);
        chk("capture during conv data", input_data, 32'd5);
        tick();
        #2 reset = 1'b0;
        #1;
        chk("async reset hex", hex, enc("--------"));
        chk("async reset data", input_data, 32'd0);
        chk("async reset busy", busy, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin tick(); if (input_valid) pulses++; end
        chk("held enter after reset", pulses, 0);
        enter = 1'b0;
        repeat (25) tick();
        enter = 1'b1;
        n = 0;
        while (!input_valid && n < 40) begin tick(); n++; end
        chk("repress after reset", input_valid, 1'b1);
        chk("repress data", input_data, 32'd5);
        enter = 1'b0;
        repeat (25) tick();

        // Halt mid-conversion, Enter ignored under halt, then fresh conversion
        in_req = 1'b0;
        out_req = 1'b1;
        output_num = 32'd99999999;
        n = 0;
        while (!busy && n < 5) begin tick(); n++; end
        chk("halt busy rise", busy, 1'b1);
        repeat (11) tick();
        halt = 1'b1;
        tick();
        chk("halt hex8", hex, enc("     End"));
        e = enc(" End");
        chk("halt hex4", hex4, e[27:0]);
        chk("halt busy", busy, 1'b0);
        out_req = 1'b0;
        in_req = 1'b1;
        enter = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin tick(); if (input_valid) pulses++; end
        chk("halt blocks enter", pulses, 0);
        enter = 1'b0;
        repeat (25) tick();
        in_req = 1'b0;
        out_req = 1'b1;
        halt = 1'b0;
        convert("after_halt", "99999999", " OFL");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_display_ctrl.md
Name: io_display_ctrl

Overview:
Parametrised successor to the processor's seven-segment I/O block. It drives NUM_DIGITS active-low seven-segment digits for OUT (processor result), IN (switch entry) and HALT modes. A sequential double-dabble engine replaces combinational divide/modulo, adds signed display, leading-zero blanking and overflow indication. Enter is debounced, and switch input is delivered to the datapath through a valid pulse.

Parameters:
NUM_DIGITS, 8, number of seven-segment digits driven (2..16)
DATA_W, 32, width of output_num and input_data (4..32)
SW_W, 10, number of switches (SW_W <= DATA_W)
DEBOUNCE_CYC, 16, consecutive stable cycles required on enter (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low; name follows the codebase reset port, polarity fixed low
in_req  in  1  processor is executing an IN instruction
out_req  in  1  processor is executing an OUT instruction
halt  in  1  processor halted
enter  in  1  raw Enter push-button, active-high, asynchronous to clk
signed_mode  in  1  1 = display the value as two's complement
sw  in  SW_W  raw switch inputs
output_num  in  DATA_W  value for OUT display
input_data  out  DATA_W  registered, zero-extended switch value captured on Enter
input_valid  out  1  one-cycle pulse when input_data updates
busy  out  1  conversion in progress
hex  out  7*NUM_DIGITS  segment codes, digit i at [7i+6:7i], active-low

Behaviour:
- Reset (async, low): all digits 7'b0111111 (dash); input_data=0; input_valid=0; busy=0; FSM=IDLE; debouncer cleared.
- Enter path:
  - 2-flop synchroniser, then a counter that must see DEBOUNCE_CYC equal samples before the debounced level changes.
  - A rising edge of the debounced level gives a one-cycle enter_pulse.
  - If enter_pulse && in_req && !out_req && !halt: input_data <= zero-extended sw, input_valid=1 on the same edge. Otherwise the pulse is discarded.
- Source select, evaluated every cycle:
  - halt: HALT mode.
  - out_req && !in_req: OUT mode, value = output_num.
  - in_req && !out_req: IN mode, value = zero-extended live sw.
  - otherwise: IDLE_DASH mode.
- HALT mode: "End" on digits 2..0 (7'b0000110, 7'b0101011, 7'b0100001), remaining digits blank 7'b1111111. Applied on the next edge and aborts any conversion.
- IDLE_DASH mode: all dashes on the next edge; any conversion is aborted.
- FSM states: IDLE, LOAD, SHIFT, FORMAT.
  - IDLE: if in OUT/IN mode and {mode, value, signed_mode} differs from the last latched copy, go to LOAD.
  - LOAD: latch the request; magnitude = -value if signed_mode && value[DATA_W-1], else value; clear BCD register; shift count = 0; busy=1.
  - SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, mag} left by 1. After DATA_W shifts go to FORMAT.
  - FORMAT: build the digit codes, update all of hex in one edge, busy=0, return to IDLE.
  - Latency from request change to hex update: DATA_W+2 cycles.
  - Any change of {mode, value, signed_mode} during LOAD/SHIFT aborts the conversion and re-enters LOAD the next cycle. hex holds its old content until a conversion completes (no flicker).
- Widths:
  - BCD register holds BCD_DIG = ceil(DATA_W*0.30103) digits.
  - The most negative value has magnitude 2^(DATA_W-1) as unsigned; this is correct, not overflow.
- Formatting:
  - Hex codes 0-9 as in the existing BCD table.
  - Zeros above the most significant nonzero digit are blank; value 0 shows a single "0" on digit 0.
  - Negative values: minus 7'b0111111 in the digit directly left of the MS nonzero digit.
  - Overflow: a nonzero BCD digit at index >= NUM_DIGITS, or a negative value needing all NUM_DIGITS digits. Display "OFL" on digits 2..0 (7'b1000000, 7'b0001110, 7'b1000111), others blank.
- Simultaneous events:
  - halt overrides enter capture and conversion in the same cycle.
  - An enter_pulse during a conversion still captures input; capture is independent of the FSM.

Decomposition:
- Shared package io_pkg:
  - seven-segment constants: SEG_BLANK, SEG_DASH, the 0-F digit table, letters E/n/d/O/F/L
  - function ceil_log10_2(DATA_W) for BCD_DIG
  - mode enumeration
- One sub-module, io_debounce (synchroniser + counter + edge pulse, parameter DEBOUNCE_CYC), reused for future keys.

Test Plan:
1. out_req=1, output_num=1234, signed_mode=0 -> busy high 34 cycles; hex digits 3..0 = "1234", digits 7..4 blank; one update edge only.
2. signed_mode=1, output_num=32'hFFFFFF85 (-123) -> digits 3..0 = "-123", rest blank; output_num=32'h80000000 -> "OFL" (-2147483648 needs 10 digits + sign).
3. in_req=1, sw=10'd1023, enter bouncing 5 cycles then held 20 cycles -> exactly one input_valid pulse, input_data=1023, 16+3 cycles after the last bounce; hex shows "1023".
4. Conversion of 99999999 in progress, halt asserted at shift 10 -> "End" next edge, busy=0; halt released with out_req still high -> fresh conversion, "99999999".
5. output_num=0 -> single "0"; NUM_DIGITS=4 instance with output_num=12345 -> "OFL".
6. reset driven low mid-SHIFT with enter held -> all dashes, input_data=0, busy=0 immediately; no input_valid until enter is re-pressed after reset release.
